grant_arbiter: RTL
==================

Name: grant_arbiter

Overview:
- Multi-requester arbiter that shares one downstream resource among PORTS requesters.
- Built around the existing priority_encoder block: one instance for fixed priority, two instances (masked and unmasked) for round-robin.
- Outputs are registered: one-hot grant, grant valid and encoded index.
- Sits between request sources (e.g. MAC/DMA channel muxes) and a shared datapath. It sequences ownership, optionally holding a grant until the owner drops its request or acknowledges.

Parameters:
- PORTS, 4, number of requesters; must be >= 2.
- TYPE, "PRIORITY", arbitration scheme: "PRIORITY" (fixed) or "ROUND_ROBIN".
- BLOCK, "NONE", grant hold policy: "NONE", "REQUEST" or "ACKNOWLEDGE".
- LSB_PRIORITY, "LOW", passed to priority_encoder: "LOW" means bit 0 wins, "HIGH" means bit PORTS-1 wins.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  PORTS  per-port request, level-sensitive.
- acknowledge  input  PORTS  per-port release strobe; used only when BLOCK="ACKNOWLEDGE".
- grant  output  PORTS  one-hot grant, registered.
- grant_valid  output  1  high when any grant bit is set, registered.
- grant_encoded  output  $clog2(PORTS)  index of the granted port, registered.

Behaviour:
- Reset, applied asynchronously:
  - grant=0, grant_valid=0, grant_encoded=0.
  - state=IDLE; round-robin mask = all ones.
- State machine:
  - IDLE: no grant held.
  - HOLD: grant held for port k. Used only when BLOCK is not "NONE".
- Arbitration:
  - Combinational pick from the current request, or from the masked request in round-robin mode.
  - Result is registered, so the latency from request to grant is exactly 1 cycle.
- Fixed priority: pick = priority_encoder(request).
- Round-robin:
  - pick = encoder(request & mask) if that is non-zero, else encoder(request).
  - After granting k with LSB_PRIORITY="LOW", mask = bits strictly above k. k=PORTS-1 gives mask 0, so the next pick falls back to unmasked (wrap).
  - With LSB_PRIORITY="HIGH", mask = bits strictly below k.
  - The mask updates only on the cycle a new grant is registered.
- BLOCK="NONE": re-arbitrate every cycle. Grant follows the pick with 1-cycle delay and may change every cycle.
- BLOCK="REQUEST":
  - HOLD on k persists while request[k]=1.
  - In the cycle request[k] is sampled low, re-arbitrate among current requests at that same edge. There is no idle bubble if others are pending; otherwise go to IDLE with grant=0.
- BLOCK="ACKNOWLEDGE":
  - HOLD on k persists until acknowledge[k]=1 is sampled, regardless of request[k].
  - On that edge, re-arbitrate as for REQUEST.
  - acknowledge on non-granted ports is ignored.
  - acknowledge[k] in the same cycle a new grant is first registered is not a release; the grant must be visible first.
- Requests arriving while in HOLD are not lost. They are evaluated at release time.
- request=0 in IDLE: outputs stay 0. grant_encoded is 0 whenever grant_valid=0.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid = |grant.
  - grant_encoded matches grant when valid.
- Reset asserted mid-HOLD: grant drops immediately (asynchronously). After deassertion, arbitration restarts from the all-ones mask.

Decomposition:
- Shared package arb_pkg holds:
  - state enum {IDLE, HOLD};
  - localparams for the TYPE and BLOCK string encodings;
  - an elaboration-time check that PORTS >= 2 and the parameter strings are legal.
- Sub-module: existing priority_encoder. Instantiate twice in round-robin mode (masked and unmasked), once in fixed priority mode. No new sub-module.

Test Plan:
- PRIORITY, NONE, PORTS=4: request=4'b1010 -> one cycle later grant=4'b0010, grant_encoded=1, valid=1. Then request=4'b1000 -> grant=4'b1000, encoded=3.
- ROUND_ROBIN, NONE: hold request=4'b1111 for 5 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap).
- ROUND_ROBIN, REQUEST: request=4'b0011, then drop bit0 after 3 cycles -> grant 0001 held 3 cycles, then 0010 on the next edge with no bubble. Drop all -> grant=0, valid=0.
- ACKNOWLEDGE: grant 0100 held while request[2] toggles low; acknowledge=4'b0001 ignored; acknowledge=4'b0100 -> next edge grants the next pending requester, or goes IDLE if none.
- Reset mid-HOLD: assert rst asynchronously while grant=0010 -> grant=0, valid=0, encoded=0 immediately. After release with request=4'b1111 in round-robin -> first grant 0001.
- Random requests/acks, all TYPE/BLOCK combinations -> assertions hold: grant one-hot-or-zero, valid=|grant, encoded consistent, no starvation within PORTS grants in round-robin.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and parameter encodings for grant_arbiter and its priority encoders.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam string TYPE_PRIORITY    = "PRIORITY";
    localparam string TYPE_ROUND_ROBIN = "ROUND_ROBIN";

    localparam string BLOCK_NONE        = "NONE";
    localparam string BLOCK_REQUEST     = "REQUEST";
    localparam string BLOCK_ACKNOWLEDGE = "ACKNOWLEDGE";

    localparam string LSB_LOW  = "LOW";
    localparam string LSB_HIGH = "HIGH";

    function automatic bit arb_ports_ok(input int ports);
        return ports >= 2;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Priority encoder: index and one-hot of the winning set bit.
// LSB_PRIORITY="LOW" lets bit 0 win, "HIGH" lets the top bit win.
module priority_encoder
    import arb_pkg::*;
#(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic [WIDTH-1:0]         input_unencoded,
    output logic                     output_valid,
    output logic [$clog2(WIDTH)-1:0] output_encoded,
    output logic [WIDTH-1:0]         output_unencoded
);

    localparam int IW = $clog2(WIDTH);

    always_comb begin
        output_encoded = '0;
        if (LSB_PRIORITY == LSB_LOW) begin
            // scan downward so the lowest set bit is written last
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) output_encoded = IW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) output_encoded = IW'(i);
            end
        end
    end

    assign output_valid     = |input_unencoded;
    assign output_unencoded = output_valid ? (WIDTH'(1) << output_encoded) : '0;

endmodule

// File: rtl/grant_arbiter.sv
// Shares one downstream resource among PORTS requesters with fixed or round-robin
// arbitration, optionally holding a grant until request drop or acknowledge.
module grant_arbiter
    import arb_pkg::*;
#(
    parameter int    PORTS        = 4,
    parameter string TYPE         = "PRIORITY",
    parameter string BLOCK        = "NONE",
    parameter string LSB_PRIORITY = "LOW"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int IW       = $clog2(PORTS);
    localparam bit IS_RR    = (TYPE == TYPE_ROUND_ROBIN);
    localparam bit IS_NONE  = (BLOCK == BLOCK_NONE);
    localparam bit IS_ACK   = (BLOCK == BLOCK_ACKNOWLEDGE);
    localparam bit IS_LOW   = (LSB_PRIORITY == LSB_LOW);
    localparam bit CFG_OK   = arb_ports_ok(PORTS)
                            && (IS_RR || TYPE == TYPE_PRIORITY)
                            && (IS_NONE || IS_ACK || BLOCK == BLOCK_REQUEST)
                            && (IS_LOW || LSB_PRIORITY == LSB_HIGH);

    if (!CFG_OK) begin : g_bad_cfg
        $error("grant_arbiter: illegal PORTS/TYPE/BLOCK/LSB_PRIORITY setting");
    end

    arb_state_t       r_state;
    logic [PORTS-1:0] r_grant;
    logic             r_valid;
    logic [IW-1:0]    r_idx;

    logic             w_u_valid;
    logic [IW-1:0]    w_u_idx;
    logic [PORTS-1:0] w_u_onehot;

    logic             w_pick_valid;
    logic [IW-1:0]    w_pick_idx;
    logic [PORTS-1:0] w_pick_onehot;

    logic             w_release;
    logic             w_arbitrate;
    logic             w_load;

    priority_encoder #(
        .WIDTH        (PORTS),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_enc (
        .input_unencoded  (request),
        .output_valid     (w_u_valid),
        .output_encoded   (w_u_idx),
        .output_unencoded (w_u_onehot)
    );

    if (IS_RR) begin : g_rr
        logic [PORTS-1:0] r_mask;
        logic [PORTS-1:0] w_next_mask;
        logic [PORTS-1:0] w_req_masked;
        logic             w_m_valid;
        logic [IW-1:0]    w_m_idx;
        logic [PORTS-1:0] w_m_onehot;

        assign w_req_masked = request & r_mask;

        priority_encoder #(
            .WIDTH        (PORTS),
            .LSB_PRIORITY (LSB_PRIORITY)
        ) u_enc_masked (
            .input_unencoded  (w_req_masked),
            .output_valid     (w_m_valid),
            .output_encoded   (w_m_idx),
            .output_unencoded (w_m_onehot)
        );

        // Next search window starts just past the port being granted.
        always_comb begin
            w_next_mask = '0;
            for (int i = 0; i < PORTS; i++) begin
                if (IS_LOW) w_next_mask[i] = (i > int'(w_pick_idx));
                else        w_next_mask[i] = (i < int'(w_pick_idx));
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)         r_mask <= '1;
            else if (w_load) r_mask <= w_next_mask;
        end

        assign w_pick_valid  = w_m_valid | w_u_valid;
        assign w_pick_idx    = w_m_valid ? w_m_idx    : w_u_idx;
        assign w_pick_onehot = w_m_valid ? w_m_onehot : w_u_onehot;
    end else begin : g_fixed
        assign w_pick_valid  = w_u_valid;
        assign w_pick_idx    = w_u_idx;
        assign w_pick_onehot = w_u_onehot;
    end

    assign w_release   = IS_ACK ? acknowledge[r_idx] : ~request[r_idx];
    assign w_arbitrate = (r_state == IDLE) || w_release;
    assign w_load      = w_arbitrate && w_pick_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (w_arbitrate) begin
            if (w_pick_valid) begin
                r_state <= IS_NONE ? IDLE : HOLD;
                r_grant <= w_pick_onehot;
                r_valid <= 1'b1;
                r_idx   <= w_pick_idx;
            end else begin
                r_state <= IDLE;
                r_grant <= '0;
                r_valid <= 1'b0;
                r_idx   <= '0;
            end
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_valid;
    assign grant_encoded = r_idx;

endmodule
